micro_op_executor: RTL
======================

MICRO_OP_EXECUTOR -- requirements
Module: micro_op_executor

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-003 SHALL have port start, input, 1 bit: operate-instruction request, accepted only while ready=1.
REQ-004 SHALL have port ready, output, 1 bit: high only in IDLE.
REQ-005 SHALL have port i_reg, input, 9 bits: operate-instruction bits 8:0, sampled on acceptance.
REQ-006 SHALL have ports ac_in (input, word, 12 bits) and l_in (input, 1 bit): AC and link, sampled on acceptance.
REQ-007 SHALL have port sr, input, word: switch register, sampled on acceptance.
REQ-008 SHALL have ports ac_out (output, word) and l_out (output, 1 bit): registered results, held until the next acceptance.
REQ-009 SHALL have port skip, output, 1 bit: registered skip result, held like ac_out.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse; results valid in that cycle.
REQ-011 SHALL have ports halt and unsupported, output, 1 bit each: set in DONE, cleared on next acceptance.

Function
REQ-012 SHALL decode group from i_reg[8], i_reg[0]: 0x = group 1; 10 = group 2; 11 = group 3; i_reg[3] SHALL select group 2 AND (1) or OR (0).
REQ-013 SHALL use states IDLE, S1, S2, S3, S4, ROT2, G2_SKIP, G2_OPS, G3, DONE; acceptance at edge 0 SHALL move IDLE->S1 (group 1), G2_SKIP (group 2) or G3 (group 3).
REQ-014 Group 1: S1 SHALL apply CLA (bit 7, AC=0) and CLL (bit 6, L=0); S2 CMA (bit 5), CML (bit 4); S3 IAC (bit 0): {L,AC}={L,AC}+1 modulo 2^13.
REQ-015 S4 SHALL apply RAR (bit 3) or RAL (bit 2) as a 13-bit rotate through L; with BSW (bit 1) also set, ROT2 SHALL repeat the rotate once.
REQ-016 BSW alone SHALL swap AC[11:6] and AC[5:0] in S4, L unchanged.
REQ-017 RAR and RAL both set SHALL leave AC/L unchanged in S4, and ROT2 SHALL NOT be entered.
REQ-018 Group 2 OR: skip=(b6&AC[11])|(b5&AC==0)|(b4&L); AND: skip=(!b6|!AC[11])&(!b5|AC!=0)&(!b4|!L); evaluated in G2_SKIP on pre-CLA AC.
REQ-019 G2_OPS SHALL apply CLA (bit 7), then OSR (bit 2: AC|=sr), then HLT (bit 1: halt=1 at DONE).
REQ-020 Group 3 SHALL apply CLA (bit 7) only in G3, and SHALL set unsupported=1 at DONE if any of i_reg[6:1] is set.
REQ-021 DONE SHALL pulse done and return to IDLE next cycle.
REQ-022 Latency from acceptance edge: group 1 done at cycle 5 (6 with ROT2), group 2 at cycle 3, group 3 at cycle 2.
REQ-023 start while ready=0 SHALL be ignored, with no queuing.
REQ-024 skip SHALL be 0 for group 1 and group 3.

Reset
REQ-025 reset SHALL force IDLE, ac_out=0, l_out=0, skip=0, done=0, halt=0, unsupported=0, ready=1 on the next edge.
REQ-026 reset SHALL take priority over start.
REQ-027 reset mid-operation SHALL abandon the instruction with no done pulse.

Structure
REQ-028 word (12-bit) SHALL come from the shared memory_utils package; state enum and instruction bit-position constants SHALL live in a shared package.
REQ-029 Group 2 skip evaluation SHALL be a combinational sub-module, micro_skip_eval.

Verification
REQ-030 i_reg=9'h0A0 (CLA CMA), ac_in=12'o1234, l_in=1 -> ac_out=12'o7777, l_out=1, done at cycle 5.
REQ-031 i_reg=9'h001 (IAC), ac_in=12'o7777, l_in=0 -> ac_out=0, l_out=1.
REQ-032 i_reg=9'h006 (RTL), ac_in=12'o4001, l_in=0 -> ac_out=12'o0005, l_out=0, done at cycle 6.
REQ-033 i_reg=9'h002 (BSW), ac_in=12'o1234 -> ac_out=12'o3412.
REQ-034 Group 2 cases, all done at cycle 3:
- i_reg=9'h1C0 (SMA CLA), ac_in=12'o4000 -> skip=1, ac_out=0.
- i_reg=9'h108 (SKP) -> skip=1.
- i_reg=9'h148 (SPA), ac_in=12'o4000 -> skip=0.
REQ-035 start pulsed in S2 -> ignored, single done. reset asserted in S3 -> no done, outputs zero, ready=1.

Source files
------------

// File: rtl/memory_utils_pkg.sv
`default_nettype none
// ============================================================================
// Package     : memory_utils
// Description : Machine word type shared by the datapath blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package memory_utils;

    localparam int WORD_W = 12;

    typedef logic [WORD_W-1:0] word;

endpackage
`default_nettype wire

// File: rtl/micro_op_executor_pkg.sv
`default_nettype none
// ============================================================================
// Package     : micro_op_executor_pkg
// Description : Operate-instruction bit positions, sequencer states and helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package micro_op_executor_pkg;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        S1      = 4'd1,
        S2      = 4'd2,
        S3      = 4'd3,
        S4      = 4'd4,
        ROT2    = 4'd5,
        G2_SKIP = 4'd6,
        G2_OPS  = 4'd7,
        G3      = 4'd8,
        DONE    = 4'd9
    } state_e;

    typedef enum logic [1:0] {
        GRP1 = 2'd0,
        GRP2 = 2'd1,
        GRP3 = 2'd2
    } grp_e;

    // Positions shared by all groups
    localparam int c_BIT_GRP = 8;
    localparam int c_BIT_CLA = 7;
    localparam int c_BIT_SUB = 0;

    // Group 1
    localparam int c_BIT_CLL = 6;
    localparam int c_BIT_CMA = 5;
    localparam int c_BIT_CML = 4;
    localparam int c_BIT_RAR = 3;
    localparam int c_BIT_RAL = 2;
    localparam int c_BIT_BSW = 1;
    localparam int c_BIT_IAC = 0;

    // Group 2
    localparam int c_BIT_SMA = 6;
    localparam int c_BIT_SZA = 5;
    localparam int c_BIT_SNL = 4;
    localparam int c_BIT_AND = 3;
    localparam int c_BIT_OSR = 2;
    localparam int c_BIT_HLT = 1;

    function automatic grp_e decode_group(input logic [8:0] ir);
        if (!ir[c_BIT_GRP])
            return GRP1;
        else if (!ir[c_BIT_SUB])
            return GRP2;
        else
            return GRP3;
    endfunction

    // One-place rotate of the 13-bit {L, AC} ring
    function automatic logic [12:0] rot13(input logic [12:0] v, input logic right);
        if (right)
            return {v[0], v[12:1]};
        else
            return {v[11:0], v[12]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/micro_op_executor_skip_eval.sv
`default_nettype none
// ============================================================================
// Module      : micro_skip_eval
// Description : Combinational group-2 skip condition (OR and AND forms).
// Revision    : 1.0 - initial release
// ============================================================================
module micro_skip_eval
    import memory_utils::*;
(
    input  logic sma_i,
    input  logic sza_i,
    input  logic snl_i,
    input  logic and_sel_i,
    input  word  ac_i,
    input  logic l_i,
    output logic skip_o
);

    logic w_or_cond;
    logic w_and_cond;

    always_comb begin
        w_or_cond  = (sma_i & ac_i[WORD_W-1])
                   | (sza_i & (ac_i == '0))
                   | (snl_i & l_i);
        w_and_cond = (~sma_i | ~ac_i[WORD_W-1])
                   & (~sza_i | (ac_i != '0))
                   & (~snl_i | ~l_i);
        skip_o     = and_sel_i ? w_and_cond : w_or_cond;
    end

endmodule
`default_nettype wire

// File: rtl/micro_op_executor.sv
`default_nettype none
// ============================================================================
// Module      : micro_op_executor
// Description : Multi-cycle sequencer for operate-class micro-instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module micro_op_executor
    import memory_utils::*, micro_op_executor_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       ready,
    input  logic [8:0] i_reg,
    input  word        ac_in,
    input  logic       l_in,
    input  word        sr,
    output word        ac_out,
    output logic       l_out,
    output logic       skip,
    output logic       done,
    output logic       halt,
    output logic       unsupported
);

    state_e      state_q, state_d;
    logic [8:0]  ir_q;
    word         sr_q;
    word         ac_q, ac_d;
    logic        l_q, l_d;
    word         ac_out_q;
    logic        l_out_q;
    logic        skip_q;
    logic        skip_eval_q;
    logic        halt_q;
    logic        unsup_q;

    logic        w_accept;
    logic        w_skip;
    logic        w_rot_one;
    grp_e        w_grp;
    grp_e        w_in_grp;
    logic [12:0] w_rot;

    assign w_accept  = (state_q == IDLE) && start;
    assign w_grp     = decode_group(ir_q);
    assign w_in_grp  = decode_group(i_reg);
    assign w_rot     = rot13({l_q, ac_q}, ir_q[c_BIT_RAR]);
    assign w_rot_one = ir_q[c_BIT_RAR] ^ ir_q[c_BIT_RAL];

    micro_skip_eval u_skip_eval (
        .sma_i     (ir_q[c_BIT_SMA]),
        .sza_i     (ir_q[c_BIT_SZA]),
        .snl_i     (ir_q[c_BIT_SNL]),
        .and_sel_i (ir_q[c_BIT_AND]),
        .ac_i      (ac_q),
        .l_i       (l_q),
        .skip_o    (w_skip)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (w_in_grp)
                        GRP1:    state_d = S1;
                        GRP2:    state_d = G2_SKIP;
                        default: state_d = G3;
                    endcase
                end
            end
            S1:      state_d = S2;
            S2:      state_d = S3;
            S3:      state_d = S4;
            S4:      state_d = (w_rot_one && ir_q[c_BIT_BSW]) ? ROT2 : DONE;
            ROT2:    state_d = DONE;
            G2_SKIP: state_d = G2_OPS;
            G2_OPS:  state_d = DONE;
            G3:      state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        ready = (state_q == IDLE);
        done  = (state_q == DONE);
    end

    // Working AC/L datapath
    always_comb begin
        ac_d = ac_q;
        l_d  = l_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    ac_d = ac_in;
                    l_d  = l_in;
                end
            end
            S1: begin
                if (ir_q[c_BIT_CLA]) ac_d = '0;
                if (ir_q[c_BIT_CLL]) l_d  = 1'b0;
            end
            S2: begin
                if (ir_q[c_BIT_CMA]) ac_d = ~ac_q;
                if (ir_q[c_BIT_CML]) l_d  = ~l_q;
            end
            S3: begin
                if (ir_q[c_BIT_IAC]) {l_d, ac_d} = {l_q, ac_q} + 13'd1;
            end
            S4: begin
                if (w_rot_one)
                    {l_d, ac_d} = w_rot;
                else if (!ir_q[c_BIT_RAR] && ir_q[c_BIT_BSW])
                    ac_d = {ac_q[5:0], ac_q[11:6]};
            end
            ROT2: {l_d, ac_d} = w_rot;
            G2_OPS: begin
                if (ir_q[c_BIT_CLA]) ac_d = '0;
                if (ir_q[c_BIT_OSR]) ac_d = ac_d | sr_q;
            end
            G3: begin
                if (ir_q[c_BIT_CLA]) ac_d = '0;
            end
            default: ;
        endcase
    end

    // Operand capture and result registers; results load on entry to DONE
    always_ff @(posedge clk) begin
        if (reset) begin
            ir_q        <= '0;
            sr_q        <= '0;
            ac_q        <= '0;
            l_q         <= 1'b0;
            ac_out_q    <= '0;
            l_out_q     <= 1'b0;
            skip_q      <= 1'b0;
            skip_eval_q <= 1'b0;
            halt_q      <= 1'b0;
            unsup_q     <= 1'b0;
        end else begin
            ac_q <= ac_d;
            l_q  <= l_d;
            if (w_accept) begin
                ir_q    <= i_reg;
                sr_q    <= sr;
                halt_q  <= 1'b0;
                unsup_q <= 1'b0;
            end
            if (state_q == G2_SKIP)
                skip_eval_q <= w_skip;
            if (state_d == DONE) begin
                ac_out_q <= ac_d;
                l_out_q  <= l_d;
                skip_q   <= (w_grp == GRP2) && skip_eval_q;
                halt_q   <= (w_grp == GRP2) && ir_q[c_BIT_HLT];
                unsup_q  <= (w_grp == GRP3) && (ir_q[6:1] != 6'd0);
            end
        end
    end

    assign ac_out      = ac_out_q;
    assign l_out       = l_out_q;
    assign skip        = skip_q;
    assign halt        = halt_q;
    assign unsupported = unsup_q;

endmodule
`default_nettype wire
